// File: rtl/rfile.sv
// General-purpose register file: 2**ADDR_WIDTH entries, two combinational read ports,
// one synchronous write port, all entries cleared by an asynchronous active-high reset.
module rfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] read_reg_1,
    input  logic [ADDR_WIDTH-1:0] read_reg_2,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    // Register 0 is an ordinary entry; there is no hardwired-zero special case.
    always_comb begin
        // NOTE: the full copy of mem_q first means every element of mem_d is assigned
        // on every path, so no latch is inferred for the untouched entries.
        mem_d = mem_q;
        if (write_en) begin
            mem_d[write_reg] = write_data;
        end
    end

    // NOTE: this array is built from flops rather than a RAM macro precisely so that every
    // entry can be cleared asynchronously; outputs are therefore never X after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // No write-to-read bypass: a same-index write shows up only after its clock edge.
    assign read_data_1 = mem_q[read_reg_1];
    assign read_data_2 = mem_q[read_reg_2];

endmodule

// File: tb/tb_rfile.sv
// Self-checking bench for rfile: directed scenarios plus randomized traffic checked
// against an array model of the register contents.
module tb_rfile;

    logic        clk;
    logic        rst;
    logic [4:0]  read_reg_1;
    logic [4:0]  read_reg_2;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    rfile #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .read_reg_1  (read_reg_1),
        .read_reg_2  (read_reg_2),
        .write_en    (write_en),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    // One rising edge; the model applies the write the spec says that edge performs.
    task automatic tick();
        @(posedge clk);
        if (!rst && write_en) model[write_reg] = write_data;
        #1;
    endtask

    task automatic do_write(input logic [4:0] idx, input logic [31:0] data);
        @(negedge clk);
        write_en   = 1'b1;
        write_reg  = idx;
        write_data = data;
        tick();
        write_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [4:0] a, input logic [4:0] b);
        read_reg_1 = a;
        read_reg_2 = b;
        #1;
        check({tag, "_rd1"}, read_data_1, model[a]);
        check({tag, "_rd2"}, read_data_2, model[b]);
    endtask

    initial begin
        logic [31:0] rnd;
        rst        = 1'b1;
        read_reg_1 = '0;
        read_reg_2 = '0;
        write_en   = 1'b0;
        write_reg  = '0;
        write_data = '0;
        model_clear();

        // Reset clears all entries
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            check("reset_rd1", read_data_1, 32'h0);
            check("reset_rd2", read_data_2, 32'h0);
        end

        // Sequential writes and paired reads
        do_write(5'd0, 32'h55);
        do_write(5'd1, 32'h75);
        do_write(5'd2, 32'hD5);
        do_write(5'd3, 32'h57);
        check_read("seq01", 5'd0, 5'd1);
        check("seq_reg0", read_data_1, 32'h55);
        check("seq_reg1", read_data_2, 32'h75);
        check_read("seq23", 5'd2, 5'd3);
        check("seq_reg2", read_data_1, 32'hD5);
        check("seq_reg3", read_data_2, 32'h57);

        // Write enable gating
        @(negedge clk);
        write_en   = 1'b0;
        write_reg  = 5'd5;
        write_data = 32'hDEADBEEF;
        tick();
        check_read("gate", 5'd5, 5'd5);
        check("gate_reg5", read_data_1, 32'h0);

        // Read-during-write: old value before the edge, new value after it
        @(negedge clk);
        read_reg_1 = 5'd7;
        read_reg_2 = 5'd7;
        write_en   = 1'b1;
        write_reg  = 5'd7;
        write_data = 32'h12345678;
        #1;
        check("rdw_before", read_data_1, 32'h0);
        tick();
        write_en = 1'b0;
        check("rdw_after", read_data_1, 32'h12345678);
        check("rdw_port2", read_data_2, 32'h12345678);

        // Asynchronous reset mid-cycle, with a coincident write dropped
        for (int i = 0; i < 4; i++) do_write(5'(i), $urandom | 32'h1);
        check_read("prefill", 5'd0, 5'd3);
        @(negedge clk);
        read_reg_1 = 5'd1;
        read_reg_2 = 5'd2;
        write_en   = 1'b1;
        write_reg  = 5'd9;
        write_data = 32'hA5A5A5A5;
        #2;
        rst = 1'b1;
        model_clear();
        #1;
        check("async_rd1", read_data_1, 32'h0);
        check("async_rd2", read_data_2, 32'h0);
        tick();
        write_en = 1'b0;
        check_read("rst_drop", 5'd9, 5'd0);
        check("rst_drop_reg9", read_data_1, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        do_write(5'd4, 32'hCAFEF00D);
        check_read("post_release", 5'd4, 5'd3);
        check("post_release_reg4", read_data_1, 32'hCAFEF00D);

        // Back-to-back writes to the same index
        do_write(5'd6, 32'h11111111);
        do_write(5'd6, 32'h22222222);
        check_read("b2b", 5'd6, 5'd4);
        check("b2b_reg6", read_data_1, 32'h22222222);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            rnd        = $urandom;
            write_en   = rnd[0];
            write_reg  = rnd[5:1];
            write_data = $urandom;
            read_reg_1 = rnd[10:6];
            read_reg_2 = (rnd[15:11] == 5'd0) ? rnd[5:1] : rnd[20:16];
            #1;
            check("rand_pre_rd1", read_data_1, model[read_reg_1]);
            check("rand_pre_rd2", read_data_2, model[read_reg_2]);
            tick();
            check("rand_post_rd1", read_data_1, model[read_reg_1]);
            check("rand_post_rd2", read_data_2, model[read_reg_2]);
        end

        // Full-range write and overwrite of reg31
        for (int i = 0; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
        do_write(5'd31, 32'hFFFFFFFF);
        for (int i = 0; i < 32; i++) begin
            read_reg_1 = 5'(i);
            read_reg_2 = 5'(31 - i);
            #1;
            check("full_rd1", read_data_1, (i == 31) ? 32'hFFFFFFFF : 32'(i) * 32'h01010101);
            check("full_rd2", read_data_2, model[31 - i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
